aes128_static_key_nsbox_core: RTL and testbench

//  Iterative AES-128 encrypt/decrypt core with a build-time static key and a parametrised count of
//  S-box lanes per cycle (1..16). It generalises the 4-S-box multicycle core: SubBytes results go
//  to a shadow register, so ShiftRows always reads an unmodified round state.
//  An optional clear cycle supports power-analysis experiments. It sits behind the board's

---
 rtl/aes128_static_key_nsbox_core_pkg.sv | 126 ++++++++++++
 rtl/aes128_static_key_nsbox_core_sbox_bank.sv | 25 ++
 rtl/aes128_static_key_nsbox_core.sv | 191 +++++++++++++++++++
 tb/tb_aes128_static_key_nsbox_core.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_static_key_nsbox_core_pkg.sv
// ============================================================================
// aes128_static_key_nsbox_core_pkg
// FSM encodings, round constants and AES byte/column/key helpers for the core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes128_static_key_nsbox_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_SUB  = 3'd2,
        ST_MIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [3:0] ENC_FIRST = 4'd1;
    localparam logic [3:0] ENC_LAST  = 4'd10;
    localparam logic [3:0] DEC_FIRST = 4'd9;
    localparam logic [3:0] DEC_LAST  = 4'd0;

    function automatic bit nsbox_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] t;
        t = gf_inv(x);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Byte i of the state sits at [127-8i -: 8]; column c, row r is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv)
                    o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
                else
                    o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [3:0][7:0] a;
        logic [3:0][7:0] k;
        logic [31:0]     o;
        k = inv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
        for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                o[31-8*r -: 8] = o[31-8*r -: 8] ^ gf_mul(k[(j-r+4)%4], a[j]);
            end
        end
        return o;
    endfunction

    // Round key r lives at [r*128 +: 128].
    function automatic logic [11*128-1:0] key_expand(input logic [127:0] key);
        logic [43:0][31:0]    w;
        logic [31:0]          t;
        logic [7:0]           rc;
        logic [11*128-1:0]    rk;
        rc = 8'h01;
        w  = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0]),
                      sub_byte(t[31:24])} ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes128_static_key_nsbox_core_sbox_bank.sv
// ============================================================================
// aes128_static_key_nsbox_core_sbox_bank
// NSBOX parallel byte substitution lanes, forward or inverse S-box per inv_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes128_static_key_nsbox_core_sbox_bank
    import aes128_static_key_nsbox_core_pkg::*;
#(
    parameter int NSBOX = 4
) (
    input  logic                 inv_i,
    input  logic [8*NSBOX-1:0]   data_i,
    output logic [8*NSBOX-1:0]   data_o
);

    for (genvar i = 0; i < NSBOX; i++) begin : g_lane
        assign data_o[8*i +: 8] = inv_i ? inv_sub_byte(data_i[8*i +: 8])
                                        : sub_byte(data_i[8*i +: 8]);
    end

endmodule

`default_nettype wire

// File: rtl/aes128_static_key_nsbox_core.sv
// ============================================================================
// aes128_static_key_nsbox_core
// Iterative AES-128 enc/dec, static key, NSBOX S-box lanes per SUB cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes128_static_key_nsbox_core
    import aes128_static_key_nsbox_core_pkg::*;
#(
    parameter logic [127:0] KEY       = 128'h00112233445566778899aabbccddeeff,
    parameter int           NSBOX     = 4,
    parameter int           CLR_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [127:0]  data_i,
    output logic [127:0]  data_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int                c_S        = 16 / NSBOX;
    localparam int                c_LW       = (c_S > 1) ? $clog2(c_S) : 1;
    localparam int                c_NB       = 8 * NSBOX;
    localparam logic [1407:0]     c_RK       = key_expand(KEY);
    localparam logic [127:0]      c_RK_FIRST = c_RK[127:0];
    localparam logic [127:0]      c_RK_LAST  = c_RK[10*128 +: 128];

    if (!nsbox_legal(NSBOX)) begin : g_bad_nsbox
        $error("NSBOX must be one of 1, 2, 4, 8, 16");
    end

    state_e              state_q, state_d;
    logic [127:0]        st_q, st_d;
    logic [127:0]        sh_q, sh_d;
    logic [127:0]        din_q, din_d;
    logic [127:0]        dout_q, dout_d;
    logic                dec_q, dec_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [c_LW-1:0]     lane_q, lane_d;

    logic [127:0]        w_sr;
    logic [127:0]        w_rk;
    logic [127:0]        w_sh_rk;
    logic [127:0]        w_mix;
    logic [127:0]        w_imix;
    logic [127:0]        w_round_out;
    logic [c_NB-1:0]     w_lane_in;
    logic [c_NB-1:0]     w_lane_out;
    logic                w_last_lane;
    logic                w_final;

    assign w_sr        = shift_rows(st_q, dec_q);
    assign w_last_lane = (lane_q == c_LW'(c_S - 1));
    assign w_final     = dec_q ? (rnd_q == DEC_LAST) : (rnd_q == ENC_LAST);
    assign w_sh_rk     = sh_q ^ w_rk;

    always_comb begin
        w_rk = '0;
        for (int r = 0; r < 11; r++) begin
            if (rnd_q == 4'(r)) w_rk = c_RK[r*128 +: 128];
        end
    end

    // The lane counter picks which NSBOX-byte slice of the shifted state is substituted.
    always_comb begin
        w_lane_in = '0;
        for (int k = 0; k < c_S; k++) begin
            if (lane_q == c_LW'(k)) w_lane_in = w_sr[127 - k*c_NB -: c_NB];
        end
    end

    aes128_static_key_nsbox_core_sbox_bank #(
        .NSBOX (NSBOX)
    ) u_sbox_bank (
        .inv_i  (dec_q),
        .data_i (w_lane_in),
        .data_o (w_lane_out)
    );

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_mix[127-32*c -: 32]  = mix_col(sh_q[127-32*c -: 32], 1'b0);
        assign w_imix[127-32*c -: 32] = mix_col(w_sh_rk[127-32*c -: 32], 1'b1);
    end

    always_comb begin
        if (dec_q) w_round_out = w_final ? w_sh_rk : w_imix;
        else       w_round_out = w_final ? w_sh_rk : (w_mix ^ w_rk);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_i)          state_d = (CLR_CYCLE != 0) ? ST_CLR : ST_SUB;
                else                 state_d = ST_IDLE;
            end
            ST_CLR:                  state_d = ST_SUB;
            ST_SUB: if (w_last_lane) state_d = ST_MIX;
            ST_MIX:                  state_d = w_final ? ST_DONE : ST_SUB;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            ST_CLR, ST_SUB, ST_MIX: busy_o = 1'b1;
            ST_DONE:                done_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        st_d   = st_q;
        sh_d   = sh_q;
        din_d  = din_q;
        dout_d = dout_q;
        dec_d  = dec_q;
        rnd_d  = rnd_q;
        lane_d = lane_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_i) begin
                    dec_d  = dec_i;
                    din_d  = data_i;
                    rnd_d  = dec_i ? DEC_FIRST : ENC_FIRST;
                    lane_d = '0;
                    if (CLR_CYCLE != 0) begin
                        st_d = '0;
                        sh_d = '0;
                    end else begin
                        st_d = data_i ^ (dec_i ? c_RK_LAST : c_RK_FIRST);
                    end
                end
            end
            ST_CLR: st_d = din_q ^ (dec_q ? c_RK_LAST : c_RK_FIRST);
            ST_SUB: begin
                // Substituted bytes land in the shadow so later lanes still see the round input.
                for (int k = 0; k < c_S; k++) begin
                    if (lane_q == c_LW'(k)) sh_d[127 - k*c_NB -: c_NB] = w_lane_out;
                end
                lane_d = w_last_lane ? '0 : lane_q + c_LW'(1);
            end
            ST_MIX: begin
                st_d = w_round_out;
                if (w_final) begin
                    dout_d = w_round_out;
                    rnd_d  = '0;
                end else begin
                    rnd_d  = dec_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= '0;
            sh_q   <= '0;
            din_q  <= '0;
            dout_q <= '0;
            dec_q  <= 1'b0;
            rnd_q  <= '0;
            lane_q <= '0;
        end else begin
            st_q   <= st_d;
            sh_q   <= sh_d;
            din_q  <= din_d;
            dout_q <= dout_d;
            dec_q  <= dec_d;
            rnd_q  <= rnd_d;
            lane_q <= lane_d;
        end
    end

    assign data_o = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_static_key_nsbox_core.sv
// ============================================================================
// tb_aes128_static_key_nsbox_core
// Self-checking bench: vector table, latency sweep and control corner cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes128_static_key_nsbox_core;

    localparam logic [127:0] c_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           c_LAT = 51;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic         dec;
    logic [127:0] din;
    logic [127:0] dout;
    logic         busy;
    logic         done;

    logic         sw_rst_n;
    logic         sw_load;
    logic         sw_dec;
    logic [127:0] sw_din;
    logic [127:0] sw_dout [8];
    logic [7:0]   sw_busy;
    logic [7:0]   sw_done;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];
    logic [7:0] rk_b    [11][16];

    typedef struct {
        logic         dec;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes128_static_key_nsbox_core #(
        .KEY       (c_KEY),
        .NSBOX     (4),
        .CLR_CYCLE (1)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .dec_i  (dec),
        .data_i (din),
        .data_o (dout),
        .busy_o (busy),
        .done_o (done)
    );

    for (genvar g = 0; g < 8; g++) begin : g_sw
        localparam int NS = (g / 2 == 0) ? 1 : (g / 2 == 1) ? 2 : (g / 2 == 2) ? 8 : 16;
        aes128_static_key_nsbox_core #(
            .KEY       (c_KEY),
            .NSBOX     (NS),
            .CLR_CYCLE (g % 2)
        ) u_sw (
            .clk    (clk),
            .rst_n  (sw_rst_n),
            .load_i (sw_load),
            .dec_i  (sw_dec),
            .data_i (sw_din),
            .data_o (sw_dout[g]),
            .busy_o (sw_busy[g]),
            .done_o (sw_done[g])
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // S-box from first principles: brute-force field inverse, then the affine map bit by bit.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_t[x]  = b;
            isbox_t[b] = 8'(x);
        end
    endtask

    task automatic expand_model(input logic [127:0] key);
        logic [7:0] kw [176];
        logic [7:0] t  [4];
        logic [7:0] tmp;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) kw[i] = key[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = kw[i-4+j];
            if (i % 16 == 0) begin
                tmp  = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[tmp];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) kw[i+j] = kw[i-16+j] ^ t[j];
        end
        for (int r = 0; r < 11; r++)
            for (int j = 0; j < 16; j++) rk_b[r][j] = kw[16*r+j];
    endtask

    // FIPS-197 cipher / inverse cipher on a byte array; byte 4c+r is row r, column c.
    function automatic logic [127:0] model(input logic [127:0] in, input logic d);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = in[127-8*i -: 8];
        if (!d) begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_b[0][i];
            for (int rnd = 1; rnd <= 10; rnd++) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                        s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_b[rnd][i];
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_b[10][i];
            for (int rnd = 9; rnd >= 0; rnd--) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c-r+4)%4)+r];
                for (int i = 0; i < 16; i++) s[i] = isbox_t[t[i]] ^ rk_b[rnd][i];
                if (rnd > 0) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
                        s[4*c+1] = gmul(a0, 9) ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
                        s[4*c+2] = gmul(a0, 13) ^ gmul(a1, 9) ^ gmul(a2, 14) ^ gmul(a3, 11);
                        s[4*c+3] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9) ^ gmul(a3, 14);
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at #1 after an edge. Accepts on the next edge, then waits for done_o.
    // hold: value data_o must keep until done_o. keep_load: hold load high and scramble inputs.
    task automatic run_op(input logic d, input logic [127:0] x, input bit keep_load,
                          input logic [127:0] hold, output logic [127:0] res,
                          output int lat, output bit bok, output bit hok);
        load = 1'b1;
        dec  = d;
        din  = x;
        @(posedge clk);
        #1;
        if (!keep_load) load = 1'b0;
        lat = 0;
        bok = busy;
        hok = 1'b1;
        while (!done && lat < 400) begin
            if (dout !== hold) hok = 1'b0;
            if (keep_load) begin
                din = rnd128();
                dec = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) bok = 1'b0;
            if (done && busy)   bok = 1'b0;
        end
        res = dout;
    endtask

    task automatic run_sweep(input logic d, input logic [127:0] x, input logic [127:0] exp,
                             input string tag);
        int           dcyc [8];
        logic [127:0] res  [8];
        int           ns_tab [4];
        int           lexp;
        ns_tab = '{1, 2, 8, 16};
        for (int g = 0; g < 8; g++) begin
            dcyc[g] = -1;
            res[g]  = '0;
        end
        sw_load = 1'b1;
        sw_dec  = d;
        sw_din  = x;
        @(posedge clk);
        #1;
        sw_load = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 8; g++) begin
                if (sw_done[g] && dcyc[g] < 0) begin
                    dcyc[g] = cyc;
                    res[g]  = sw_dout[g];
                end
            end
        end
        for (int g = 0; g < 8; g++) begin
            lexp = 10 * (16 / ns_tab[g/2] + 1) + (g % 2);
            chk($sformatf("%s_ns%0d_clr%0d_data", tag, ns_tab[g/2], g % 2), res[g], exp);
            chk($sformatf("%s_ns%0d_clr%0d_lat", tag, ns_tab[g/2], g % 2), 128'(dcyc[g]), 128'(lexp));
        end
    endtask

    initial begin
        logic [127:0] prev;
        logic [127:0] res;
        logic [127:0] res1;
        logic [127:0] x;
        int           lat;
        bit           bok;
        bit           hok;
        int           seen;

        rst_n    = 1'b0;
        sw_rst_n = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
        din      = '0;
        sw_load  = 1'b0;
        sw_dec   = 1'b0;
        sw_din   = '0;

        build_tables();
        expand_model(c_KEY);

        vt[0] = '{dec: 1'b0, din: c_PT, exp: c_CT};
        vt[1] = '{dec: 1'b1, din: c_CT, exp: c_PT};
        for (int i = 2; i < 8; i++) begin
            vt[i].dec = 1'($urandom);
            vt[i].din = rnd128();
            vt[i].exp = model(vt[i].din, vt[i].dec);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_o", dout, '0);
        chk("reset_busy_o", 128'(busy), 128'(0));
        chk("reset_done_o", 128'(done), 128'(0));
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Main table: FIPS-197 pair plus random enc/dec vectors.
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].dec, vt[i].din, 1'b0, prev, res, lat, bok, hok);
            chk($sformatf("vec%0d_data", i), res, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(c_LAT));
            chk($sformatf("vec%0d_busy_profile", i), 128'(bok), 128'(1));
            chk($sformatf("vec%0d_data_o_hold", i), 128'(hok), 128'(1));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_one_cycle", i), 128'({done, busy}), 128'(0));
            prev = res;
        end

        // NSBOX / CLR_CYCLE sweep.
        run_sweep(1'b0, c_PT, c_CT, "sweep_enc");
        run_sweep(1'b1, c_CT, c_PT, "sweep_dec");

        // load_i held high with inputs scrambled during busy; second accept in the done cycle.
        run_op(1'b0, c_PT, 1'b1, prev, res1, lat, bok, hok);
        chk("held_first_data", res1, c_CT);
        chk("held_first_latency", 128'(lat), 128'(c_LAT));
        chk("held_first_hold", 128'(hok), 128'(1));
        run_op(1'b1, c_CT, 1'b1, res1, res, lat, bok, hok);
        chk("held_second_data", res, c_PT);
        chk("held_second_latency", 128'(lat), 128'(c_LAT));
        chk("held_second_hold", 128'(hok), 128'(1));
        load = 1'b0;
        @(posedge clk);
        #1;
        chk("held_release_idle", 128'({done, busy}), 128'(0));
        prev = res;

        // Synchronous reset pulse around round 5.
        load = 1'b1;
        dec  = 1'b0;
        din  = c_PT;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        chk("abort_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy_o", 128'(busy), 128'(0));
        chk("abort_data_o", dout, '0);
        chk("abort_done_o", 128'(done), 128'(0));
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("abort_stays_idle", 128'(seen), 128'(0));
        run_op(1'b0, c_PT, 1'b0, '0, res, lat, bok, hok);
        chk("abort_fresh_data", res, c_CT);
        chk("abort_fresh_latency", 128'(lat), 128'(c_LAT));

        // Back-to-back random encrypt then decrypt of its result.
        x = rnd128();
        run_op(1'b0, x, 1'b0, res, res1, lat, bok, hok);
        chk("b2b_enc_data", res1, model(x, 1'b0));
        chk("b2b_enc_hold", 128'(hok), 128'(1));
        run_op(1'b1, res1, 1'b0, res1, res, lat, bok, hok);
        chk("b2b_dec_data", res, x);
        chk("b2b_dec_latency", 128'(lat), 128'(c_LAT));
        chk("b2b_dec_hold", 128'(hok), 128'(1));
        chk("b2b_dec_busy_profile", 128'(bok), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
